edge_detector_bank: RTL and testbench
=====================================

# edge_detector_bank

Multi-channel, parametrised edge detector for asynchronous or noisy single-bit inputs such as buttons, switches and external strobes. Each channel synchronises its input, filters glitches with a stability counter, detects rising, falling or both edges as selected per channel, and emits a one-cycle pulse plus a sticky event flag. A single interrupt request summarises all enabled flags. The block sits between board-level inputs and control FSMs, and replaces ad-hoc single-bit edge logic.

## Interface
- N_CH, 8: number of independent channels (≥1)
- SYNC_STAGES, 2: synchroniser flops per channel (≥2)
- FILTER_LEN, 4: consecutive stable cycles required to accept a new level (≥1); counter width is $clog2(FILTER_LEN+1)
- clk  input  1  single clock; all logic on posedge
- rst  input  1  synchronous, active-high reset
- sig_in  input  N_CH  raw asynchronous inputs
- mode  input  2*N_CH  per channel, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
- irq_en  input  N_CH  per-channel interrupt enable
- clr  input  N_CH  write-one-to-clear for evt_flag
- level_out  output  N_CH  filtered level
- edge_pulse  output  N_CH  one-cycle pulse on a qualified edge
- edge_dir  output  N_CH  1 = rising, 0 = falling; valid while edge_pulse is high and holds its last value otherwise
- evt_flag  output  N_CH  sticky event flag
- irq  output  1  |(evt_flag & irq_en)

## Operation
- Sync: sig_in[i] passes through a SYNC_STAGES flop chain. The chain output is s.
- Filter: the filtered level is f, and cnt is the stability counter.
  - If s == f: cnt <= 0.
  - Else if cnt == FILTER_LEN-1: f <= s and cnt <= 0. This is an update event.
  - Else: cnt <= cnt+1.
  - Any bounce back to s == f before the update event resets cnt, so no edge is produced.
- Edge: on an update event, edge_pulse[i] <= 1 if mode permits that direction, and edge_dir[i] <= new f. Otherwise edge_pulse[i] <= 0.
- mode is sampled on the update cycle only. Changing mode never disturbs sync, filter or flag state.
- mode 00: filtering and level_out continue, but no pulse and no flag are produced.
- Flags: evt_flag[i] is set by edge_pulse[i] and cleared by clr[i]. When set and clear coincide in the same cycle, set wins.
- irq is a combinational OR of registered flags, so there is no combinational path from sig_in or mode to irq.

## Timing
- Reset values: sync chain, f, cnt, level_out, edge_pulse, edge_dir, evt_flag and irq are all 0.
- Latency: an input change first captured at edge 1 gives edge_pulse high in the cycle after edge SYNC_STAGES+FILTER_LEN (6 with defaults). level_out changes at the same edge.
- edge_pulse lasts exactly 1 cycle. The minimum spacing between two pulses on one channel is FILTER_LEN cycles.
- evt_flag rises 1 cycle after edge_pulse, and irq follows in the same cycle as evt_flag.
- Reset mid-operation: all state clears on the next edge and any pending count is discarded.
- An input held high through reset produces a rising edge SYNC_STAGES+FILTER_LEN cycles after rst deasserts, if mode permits.
- Channels are fully independent. Simultaneous events on multiple channels are all reported in the same cycle.

## Structure
- Package edge_det_pkg holds:
  - mode constants MODE_OFF = 2'b00, MODE_RISE = 2'b01, MODE_FALL = 2'b10, MODE_BOTH = 2'b11;
  - a counter-width helper function.
- Sub-module edge_det_channel contains the sync chain, filter, edge qualification and sticky flag for one channel. It is instantiated N_CH times in a generate loop.
- The top level contains only the generate loop and the irq reduction.

## Test plan
- Rise, mode 01, defaults: sig_in[0] 0→1 → edge_pulse[0]=1 for one cycle at edge 6, edge_dir[0]=1, evt_flag[0]=1 at edge 7, irq=1 if irq_en[0].
- Glitch: sig_in[1] high for 3 cycles, then low, FILTER_LEN=4 → no pulse, level_out[1] stays 0, evt_flag[1]=0.
- Both edges, mode 11: a 10-cycle high pulse on ch2 → rise pulse (dir=1), then fall pulse (dir=0) exactly 10 cycles later. Mode 10 with the same stimulus → only the fall pulse.
- Flag set/clear collision: assert clr[3] in the same cycle edge_pulse[3] is high → evt_flag[3] stays 1. A later clr[3] pulse → 0, and irq drops in the same cycle.
- Reset mid-count: assert rst while cnt=2 → all outputs 0 next cycle. sig_in held high → rising pulse 6 cycles after rst release.
- Multi-channel: all 8 channels toggle in the same cycle with mixed modes → pulses appear only on channels whose mode matches, all in one cycle; irq = OR of enabled flags.

Source files
------------

// File: rtl/edge_det_pkg.sv
// Shared definitions for the edge detector bank.
//   MODE_*    : per-channel edge selection codes
//   cnt_width : width of the glitch-filter stability counter for a given filter length
package edge_det_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    // Counter must hold values 0..filter_len.
    function automatic int unsigned cnt_width(input int unsigned filter_len);
        return unsigned'($clog2(filter_len + 1));
    endfunction

endpackage

// File: rtl/edge_det_if.sv
// Signal bundle between the edge detector bank and its user.
//   sig_in     : raw asynchronous inputs, one per channel
//   mode       : 2 bits per channel, {00 off, 01 rise, 10 fall, 11 both}
//   irq_en     : per-channel interrupt enable
//   clr        : write-one-to-clear for evt_flag
//   level_out  : filtered level per channel
//   edge_pulse : one-cycle pulse on a qualified edge
//   edge_dir   : 1 = rising, 0 = falling; meaningful while edge_pulse is high
//   evt_flag   : sticky event flags
//   irq        : OR of enabled event flags
// master drives the inputs (user side), slave is the detector bank.
interface edge_det_if #(
    parameter int unsigned N_CH = 8
);
    logic [N_CH-1:0]   sig_in;
    logic [2*N_CH-1:0] mode;
    logic [N_CH-1:0]   irq_en;
    logic [N_CH-1:0]   clr;
    logic [N_CH-1:0]   level_out;
    logic [N_CH-1:0]   edge_pulse;
    logic [N_CH-1:0]   edge_dir;
    logic [N_CH-1:0]   evt_flag;
    logic              irq;

    modport master (
        output sig_in, mode, irq_en, clr,
        input  level_out, edge_pulse, edge_dir, evt_flag, irq
    );

    modport slave (
        input  sig_in, mode, irq_en, clr,
        output level_out, edge_pulse, edge_dir, evt_flag, irq
    );
endinterface

// File: rtl/edge_det_channel.sv
// One channel of the edge detector: synchroniser, glitch filter, edge qualification and
// sticky event flag.
//   clk, rst : clock and synchronous active-high reset
//   sig_i    : raw asynchronous input
//   mode_i   : edge selection (MODE_* from edge_det_pkg), sampled only on a level update
//   clr_i    : write-one-to-clear for the event flag (a simultaneous set wins)
//   level_o  : filtered level
//   pulse_o  : one-cycle pulse on a qualified edge
//   dir_o    : direction of the most recent accepted level change (1 = rising)
//   flag_o   : sticky event flag
module edge_det_channel
    import edge_det_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sig_i,
    input  logic [1:0] mode_i,
    input  logic       clr_i,
    output logic       level_o,
    output logic       pulse_o,
    output logic       dir_o,
    output logic       flag_o
);

    localparam int unsigned    CntW   = cnt_width(FILTER_LEN);
    localparam logic [CntW-1:0] CntMax = CntW'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   level_q, level_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   pulse_q, pulse_d;
    logic                   dir_q, dir_d;
    logic                   flag_q, flag_d;

    logic s;
    logic update;
    logic permit;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], sig_i};
        s       = sync_q[SYNC_STAGES-1];
        level_d = level_q;
        cnt_d   = cnt_q;
        update  = 1'b0;

        // A bounce back to the current level discards any partial count.
        if (s == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            level_d = s;
            cnt_d   = '0;
            update  = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // s is the new level on an update, so it also encodes the edge direction.
        permit = 1'b0;
        unique case (mode_i)
            MODE_OFF:  permit = 1'b0;
            MODE_RISE: permit = s;
            MODE_FALL: permit = ~s;
            MODE_BOTH: permit = 1'b1;
        endcase

        pulse_d = update & permit;
        dir_d   = update ? s : dir_q;
        // Set has priority over clear.
        flag_d  = pulse_q | (flag_q & ~clr_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            dir_q   <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            dir_q   <= dir_d;
            flag_q  <= flag_d;
        end
    end

    assign level_o = level_q;
    assign pulse_o = pulse_q;
    assign dir_o   = dir_q;
    assign flag_o  = flag_q;

endmodule

// File: rtl/edge_detector_bank.sv
// Multi-channel edge detector with glitch filtering, per-channel edge selection, sticky
// event flags and a summary interrupt.
//   clk, rst : clock and synchronous active-high reset
//   bus_io   : edge_det_if slave port carrying all per-channel inputs and outputs
// irq is built only from registered flags, so sig_in and mode never reach it combinationally.
module edge_detector_bank
    import edge_det_pkg::*;
#(
    parameter int unsigned N_CH        = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 4
) (
    input  logic        clk,
    input  logic        rst,
    edge_det_if.slave   bus_io
);

    logic [N_CH-1:0] level;
    logic [N_CH-1:0] pulse;
    logic [N_CH-1:0] dir;
    logic [N_CH-1:0] flag;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        edge_det_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_LEN  (FILTER_LEN)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .sig_i   (bus_io.sig_in[i]),
            .mode_i  (bus_io.mode[2*i +: 2]),
            .clr_i   (bus_io.clr[i]),
            .level_o (level[i]),
            .pulse_o (pulse[i]),
            .dir_o   (dir[i]),
            .flag_o  (flag[i])
        );
    end

    assign bus_io.level_out  = level;
    assign bus_io.edge_pulse = pulse;
    assign bus_io.edge_dir   = dir;
    assign bus_io.evt_flag   = flag;
    assign bus_io.irq        = |(flag & bus_io.irq_en);

endmodule

// File: tb/tb_edge_detector_bank.sv
// Self-checking bench for edge_detector_bank: directed scenarios plus randomized noise,
// compared every cycle against a behavioural model built from delay lines and a sliding
// window of synchronised samples.
module tb_edge_detector_bank;
    import edge_det_pkg::*;

    localparam int unsigned N  = 8;
    localparam int unsigned SS = 2;
    localparam int unsigned FL = 4;
    localparam int unsigned MW = 2 * N;
    localparam int          LAT = SS + FL;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    edge_det_if #(.N_CH(N)) bus ();

    edge_detector_bank #(
        .N_CH        (N),
        .SYNC_STAGES (SS),
        .FILTER_LEN  (FL)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic permits(input logic [1:0] md, input logic lvl);
        return (md == MODE_BOTH) || (md == MODE_RISE && lvl) || (md == MODE_FALL && !lvl);
    endfunction

    logic [N-1:0] raw_q[$];   // raw samples still inside the synchroniser
    logic [N-1:0] s_hist[$];  // last FL synchronised samples
    logic [N-1:0] m_level, m_pulse, m_dir, m_flag;

    always @(posedge clk) begin : model
        logic [N-1:0] s_now;
        bit           stable;
        if (rst) begin
            raw_q = {};
            repeat (SS) raw_q.push_back('0);
            s_hist  = {};
            m_level = '0;
            m_pulse = '0;
            m_dir   = '0;
            m_flag  = '0;
        end else begin
            m_flag = m_pulse | (m_flag & ~bus.clr);
            s_now  = raw_q.pop_front();
            raw_q.push_back(bus.sig_in);
            s_hist.push_back(s_now);
            if (s_hist.size() > FL) void'(s_hist.pop_front());
            for (int i = 0; i < N; i++) begin
                // New level accepted once FL consecutive samples disagree with it.
                stable = (s_hist.size() == FL);
                foreach (s_hist[j]) if (s_hist[j][i] == m_level[i]) stable = 0;
                m_pulse[i] = stable && permits(bus.mode[2*i +: 2], s_now[i]);
                if (stable) begin
                    m_level[i] = s_now[i];
                    m_dir[i]   = s_now[i];
                end
            end
        end
    end

    task automatic compare_all();
        check("level", 32'(bus.level_out), 32'(m_level));
        check("pulse", 32'(bus.edge_pulse), 32'(m_pulse));
        check("dir", 32'(bus.edge_dir & m_pulse), 32'(m_dir & m_pulse));
        check("flag", 32'(bus.evt_flag), 32'(m_flag));
        check("irq", 32'(bus.irq), 32'(|(m_flag & bus.irq_en)));
    endtask

    task automatic cycle();
        @(negedge clk);
        cyc++;
        compare_all();
    endtask

    // Counts cycles until edge_pulse[ch]; n = 0 when nothing arrives within the budget.
    task automatic wait_pulse(input int ch, output int n);
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (bus.edge_pulse[ch]) begin
                n = k;
                break;
            end
        end
    endtask

    // Drives a high pulse of 'width' cycles and records when rise/fall pulses appear.
    task automatic run_pulse(input int ch, input int width, output int t_rise, output int t_fall);
        t_rise = 0;
        t_fall = 0;
        bus.sig_in[ch] = 1'b1;
        for (int k = 1; k <= width + 2 * LAT + 4; k++) begin
            cycle();
            if (bus.edge_pulse[ch]) begin
                if (bus.edge_dir[ch]) t_rise = k;
                else                  t_fall = k;
            end
            if (k == width) bus.sig_in[ch] = 1'b0;
        end
    endtask

    initial begin : stim
        int            n, tr, tf;
        logic          seen;
        logic [N-1:0]  exp_v;
        bit            noisy;

        rst        = 1'b1;
        bus.sig_in = '0;
        bus.mode   = '1;
        bus.irq_en = '1;
        bus.clr    = '0;
        repeat (3) cycle();
        check("reset_level", 32'(bus.level_out), 32'd0);
        check("reset_flag", 32'(bus.evt_flag), 32'd0);
        check("reset_irq", 32'(bus.irq), 32'd0);
        rst = 1'b0;
        repeat (2) cycle();

        // Rise on ch0 in rise mode.
        bus.mode      = {N{MODE_RISE}};
        bus.sig_in[0] = 1'b1;
        wait_pulse(0, n);
        check("rise_latency", 32'(n), 32'(LAT));
        check("rise_dir", 32'(bus.edge_dir[0]), 32'd1);
        cycle();
        check("rise_width", 32'(bus.edge_pulse[0]), 32'd0);
        check("rise_flag", 32'(bus.evt_flag[0]), 32'd1);
        check("rise_irq", 32'(bus.irq), 32'd1);

        // Three-cycle glitch on ch1 is filtered out.
        seen          = 1'b0;
        bus.sig_in[1] = 1'b1;
        repeat (3) cycle();
        bus.sig_in[1] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            cycle();
            seen |= bus.edge_pulse[1] | bus.level_out[1];
        end
        check("glitch_seen", 32'(seen), 32'd0);
        check("glitch_flag", 32'(bus.evt_flag[1]), 32'd0);

        // Ten-cycle pulse on ch2: both edges, then fall only.
        bus.mode[5:4] = MODE_BOTH;
        run_pulse(2, 10, tr, tf);
        check("both_rise_t", 32'(tr), 32'(LAT));
        check("both_fall_t", 32'(tf), 32'(LAT + 10));
        bus.mode[5:4] = MODE_FALL;
        run_pulse(2, 10, tr, tf);
        check("fall_rise_t", 32'(tr), 32'd0);
        check("fall_fall_t", 32'(tf), 32'(LAT + 10));

        // Set/clear collision on ch3.
        bus.irq_en    = 8'h08;
        bus.mode[7:6] = MODE_BOTH;
        bus.sig_in[3] = 1'b1;
        wait_pulse(3, n);
        check("coll_latency", 32'(n), 32'(LAT));
        bus.clr[3] = 1'b1;
        cycle();
        bus.clr[3] = 1'b0;
        check("coll_flag", 32'(bus.evt_flag[3]), 32'd1);
        check("coll_irq", 32'(bus.irq), 32'd1);
        bus.clr[3] = 1'b1;
        cycle();
        bus.clr[3] = 1'b0;
        check("clr_flag", 32'(bus.evt_flag[3]), 32'd0);
        check("clr_irq", 32'(bus.irq), 32'd0);

        // Reset while ch4 is part-way through its count.
        bus.mode[9:8] = MODE_RISE;
        bus.sig_in[4] = 1'b1;
        repeat (4) cycle();
        rst = 1'b1;
        cycle();
        check("rst_pulse", 32'(bus.edge_pulse), 32'd0);
        check("rst_level", 32'(bus.level_out), 32'd0);
        check("rst_flag", 32'(bus.evt_flag), 32'd0);
        check("rst_irq", 32'(bus.irq), 32'd0);
        rst = 1'b0;
        wait_pulse(4, n);
        check("rst_latency", 32'(n), 32'(LAT));

        // All channels toggle together with mixed modes.
        bus.mode      = MW'($urandom);
        bus.mode[1:0] = MODE_BOTH;
        bus.irq_en    = N'($urandom);
        repeat (12) cycle();
        bus.clr = '1;
        cycle();
        bus.clr    = '0;
        bus.sig_in = ~bus.sig_in;
        for (int i = 0; i < N; i++) exp_v[i] = permits(bus.mode[2*i +: 2], bus.sig_in[i]);
        wait_pulse(0, n);
        check("multi_latency", 32'(n), 32'(LAT));
        check("multi_pulse", 32'(bus.edge_pulse), 32'(exp_v));
        cycle();
        check("multi_flag", 32'(bus.evt_flag), 32'(exp_v));
        check("multi_irq", 32'(bus.irq), 32'(|(exp_v & bus.irq_en)));

        // Randomized noise with occasional mode, enable, clear and reset activity.
        noisy = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            cycle();
            rst     = 1'b0;
            bus.clr = '0;
            if ($urandom_range(0, 299) == 0) noisy = !noisy;
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, noisy ? 2 : 11) == 0) bus.sig_in[i] = ~bus.sig_in[i];
            if ($urandom_range(0, 49) == 0) bus.mode = MW'($urandom);
            if ($urandom_range(0, 39) == 0) bus.irq_en = N'($urandom);
            if ($urandom_range(0, 7) == 0) bus.clr = N'($urandom);
            if ($urandom_range(0, 399) == 0) rst = 1'b1;
        end
        rst = 1'b0;
        repeat (2) cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
